// File: rtl/cpu_mem_router_pkg.sv
// Shared types and helpers for the CPU-to-memory channel router.
// Provides the FSM state encoding, error word default and byte-lane merge.
package router_pkg;

  localparam int N_CH_MAX = 8;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RMW_RD,
    S_RMW_WR,
    S_WR_WAIT,
    S_RESP_ERR
  } state_t;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] byte_merge(
    input logic [31:0] new_w,
    input logic [31:0] old_w,
    input logic [3:0]  strb
  );
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_w[8*i +: 8]
                              : old_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/cpu_mem_router_decode.sv
// Address window compare with lowest-index priority.
// Produces the winning channel index and a hit flag.
module router_decode
  import router_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int AW   = 32,
  parameter int SW   = 1,
  parameter logic [N_CH*AW-1:0] REGION_BASE  = '0,
  parameter logic [N_CH*AW-1:0] REGION_LIMIT = '0
) (
  input  logic [AW-1:0] i_addr,
  output logic [SW-1:0] o_sel,
  output logic          o_hit
);

  always_comb begin
    o_sel = '0;
    o_hit = 1'b0;
    // Walk downward so the lowest matching index is the last write.
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (i_addr >= REGION_BASE[i*AW +: AW] &&
          i_addr <= REGION_LIMIT[i*AW +: AW]) begin
        o_sel = SW'(i);
        o_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_mem_router.sv
// CPU bus router: window decode, RMW for partial stores, timeout/error.
// Optional ROUTER_PERF_EN adds per-channel request and stall counters.
module cpu_mem_router
  import router_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int AW   = 32,
  parameter logic [N_CH*AW-1:0] REGION_BASE =
    {32'h0000_0A90, 32'h0000_0000},
  parameter logic [N_CH*AW-1:0] REGION_LIMIT =
    {32'hFFFF_FFFF, 32'h0000_0A8C},
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [AW-1:0]        rw_address,
  input  logic                 read_request,
  input  logic                 write_request,
  input  logic [31:0]          write_data,
  input  logic [3:0]           write_strobe,
  output logic [31:0]          read_data,
  output logic                 read_response,
  output logic                 write_response,
  output logic [N_CH-1:0]      ch_read,
  output logic [N_CH-1:0]      ch_write,
  output logic [AW-1:0]        ch_address,
  output logic [31:0]          ch_write_data,
  input  logic [N_CH*32-1:0]   ch_read_data,
  input  logic [N_CH-1:0]      ch_ready,
`ifdef ROUTER_PERF_EN
  output logic [N_CH*32-1:0]   perf_req_cnt,
  output logic [N_CH*32-1:0]   perf_stall_cnt,
`endif
  output logic                 err_o
);

  localparam int SW = sel_w(N_CH);

  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic [3:0]    r_strb;
  logic [SW-1:0] r_sel;
  logic          r_is_rd;
  logic          r_pend;
  logic [31:0]   r_cnt;

  logic [AW-1:0] w_dec_addr;
  logic [SW-1:0] w_sel;
  logic          w_hit;
  logic          w_ready;
  logic [31:0]   w_rdata;
  logic          w_tmo;
  logic          w_wait;

  // A pending read reuses the address latched with the write.
  assign w_dec_addr = r_pend ? r_addr : rw_address;
  assign w_ready    = ch_ready[r_sel];
  assign w_rdata    = ch_read_data[32*r_sel +: 32];
  assign w_tmo      = (TIMEOUT_CYCLES != 0) &&
                      (r_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign w_wait     = (r_state == S_RD_WAIT) ||
                      (r_state == S_RMW_RD)  ||
                      (r_state == S_RMW_WR)  ||
                      (r_state == S_WR_WAIT);
  assign ch_address = r_addr;

  router_decode #(
    .N_CH        (N_CH),
    .AW          (AW),
    .SW          (SW),
    .REGION_BASE (REGION_BASE),
    .REGION_LIMIT(REGION_LIMIT)
  ) u_dec (
    .i_addr(w_dec_addr),
    .o_sel (w_sel),
    .o_hit (w_hit)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state        <= S_IDLE;
      r_addr         <= '0;
      r_strb         <= '0;
      r_sel          <= '0;
      r_is_rd        <= 1'b0;
      r_pend         <= 1'b0;
      r_cnt          <= '0;
      read_data      <= '0;
      read_response  <= 1'b0;
      write_response <= 1'b0;
      ch_read        <= '0;
      ch_write       <= '0;
      ch_write_data  <= '0;
      err_o          <= 1'b0;
    end else begin
      read_response  <= 1'b0;
      write_response <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (r_pend) begin
            r_pend  <= 1'b0;
            r_sel   <= w_sel;
            r_is_rd <= 1'b1;
            r_cnt   <= '0;
            if (!w_hit) begin
              r_state <= S_RESP_ERR;
            end else begin
              ch_read[w_sel] <= 1'b1;
              r_state        <= S_RD_WAIT;
            end
          end else if (write_request) begin
            r_addr        <= rw_address;
            ch_write_data <= write_data;
            r_strb        <= write_strobe;
            r_sel         <= w_sel;
            r_is_rd       <= 1'b0;
            r_pend        <= read_request;
            r_cnt         <= '0;
            if (write_strobe == 4'h0) begin
              write_response <= 1'b1;
            end else if (!w_hit) begin
              r_state <= S_RESP_ERR;
            end else if (write_strobe == 4'hF) begin
              ch_write[w_sel] <= 1'b1;
              r_state         <= S_WR_WAIT;
            end else begin
              ch_read[w_sel] <= 1'b1;
              r_state        <= S_RMW_RD;
            end
          end else if (read_request) begin
            r_addr  <= rw_address;
            r_sel   <= w_sel;
            r_is_rd <= 1'b1;
            r_cnt   <= '0;
            if (!w_hit) begin
              r_state <= S_RESP_ERR;
            end else begin
              ch_read[w_sel] <= 1'b1;
              r_state        <= S_RD_WAIT;
            end
          end
        end
        S_RD_WAIT: begin
          if (w_ready) begin
            ch_read       <= '0;
            read_data     <= w_rdata;
            read_response <= 1'b1;
            r_state       <= S_IDLE;
          end else if (w_tmo) begin
            ch_read <= '0;
            r_state <= S_RESP_ERR;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_RMW_RD: begin
          if (w_ready) begin
            ch_read        <= '0;
            ch_write_data  <= byte_merge(ch_write_data,
                                         w_rdata, r_strb);
            ch_write[r_sel] <= 1'b1;
            r_cnt          <= '0;
            r_state        <= S_RMW_WR;
          end else if (w_tmo) begin
            ch_read <= '0;
            r_state <= S_RESP_ERR;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_RMW_WR, S_WR_WAIT: begin
          if (w_ready) begin
            ch_write       <= '0;
            write_response <= 1'b1;
            r_state        <= S_IDLE;
          end else if (w_tmo) begin
            ch_write <= '0;
            r_state  <= S_RESP_ERR;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_RESP_ERR: begin
          err_o <= 1'b1;
          if (r_is_rd) begin
            read_data     <= ERR_DATA;
            read_response <= 1'b1;
          end else begin
            write_response <= 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ROUTER_PERF_EN
  logic w_start;

  assign w_start = (r_state == S_IDLE) && w_hit &&
                   (r_pend || read_request ||
                    (write_request && write_strobe != 4'h0));

  for (genvar c = 0; c < N_CH; c++) begin : g_perf
    logic [31:0] r_req;
    logic [31:0] r_stall;

    always_ff @(posedge clk) begin
      if (!rstn) begin
        r_req   <= '0;
        r_stall <= '0;
      end else begin
        if (w_start && w_sel == SW'(c) && r_req != '1)
          r_req <= r_req + 32'd1;
        if (w_wait && r_sel == SW'(c) && !w_ready &&
            r_stall != '1)
          r_stall <= r_stall + 32'd1;
      end
    end

    assign perf_req_cnt[32*c +: 32]   = r_req;
    assign perf_stall_cnt[32*c +: 32] = r_stall;
  end
`endif

endmodule

// File: tb/tb_cpu_mem_router.sv
// Directed self-checking bench for cpu_mem_router.
// Runs with an 8-cycle timeout so the abort path is reachable.
module tb_cpu_mem_router;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] rw_address;
  logic        read_request;
  logic        write_request;
  logic [31:0] write_data;
  logic [3:0]  write_strobe;
  logic [31:0] read_data;
  logic        read_response;
  logic        write_response;
  logic [1:0]  ch_read;
  logic [1:0]  ch_write;
  logic [31:0] ch_address;
  logic [31:0] ch_write_data;
  logic [63:0] ch_read_data;
  logic [1:0]  ch_ready;
  logic        err_o;
`ifdef ROUTER_PERF_EN
  logic [63:0] perf_req_cnt;
  logic [63:0] perf_stall_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cpu_mem_router #(
    .N_CH          (2),
    .AW            (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .rw_address    (rw_address),
    .read_request  (read_request),
    .write_request (write_request),
    .write_data    (write_data),
    .write_strobe  (write_strobe),
    .read_data     (read_data),
    .read_response (read_response),
    .write_response(write_response),
    .ch_read       (ch_read),
    .ch_write      (ch_write),
    .ch_address    (ch_address),
    .ch_write_data (ch_write_data),
    .ch_read_data  (ch_read_data),
    .ch_ready      (ch_ready),
`ifdef ROUTER_PERF_EN
    .perf_req_cnt  (perf_req_cnt),
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .err_o         (err_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    rw_address = '0;
    read_request = 1'b0;
    write_request = 1'b0;
    write_data = '0;
    write_strobe = '0;
    ch_read_data = '0;
    ch_ready = '0;
    tick();
    tick();
    n_vec++;
    if ({read_response, write_response, ch_read, ch_write,
         err_o} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_ctl act=%b req=0",
               {read_response, write_response, ch_read,
                ch_write, err_o});
    end
    n_vec++;
    if ({read_data, ch_address, ch_write_data} !== 96'b0) begin
      n_err++;
      $display("FAIL reset_data act=%h req=0",
               {read_data, ch_address, ch_write_data});
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_read();
    rw_address = 32'h0000_0100;
    read_request = 1'b1;
    tick();
    read_request = 1'b0;
    n_vec++;
    if (ch_read !== 2'b01 || ch_address !== 32'h100) begin
      n_err++;
      $display("FAIL rd_issue ch_read=%b addr=%h req=01/100",
               ch_read, ch_address);
    end
    tick();
    ch_ready = 2'b10;
    tick();
    ch_ready = 2'b00;
    n_vec++;
    if (ch_read !== 2'b01 || read_response !== 1'b0) begin
      n_err++;
      $display("FAIL rd_wrong_ready ch_read=%b rsp=%b req=01/0",
               ch_read, read_response);
    end
    ch_ready = 2'b01;
    ch_read_data[31:0] = 32'h1234_5678;
    tick();
    ch_ready = 2'b00;
    n_vec++;
    if (read_response !== 1'b1 || read_data !== 32'h1234_5678 ||
        ch_read !== 2'b00) begin
      n_err++;
      $display("FAIL rd_resp rsp=%b data=%h ch=%b req=1/12345678/00",
               read_response, read_data, ch_read);
    end
    tick();
    n_vec++;
    if (read_response !== 1'b0 || read_data !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL rd_hold rsp=%b data=%h req=0/12345678",
               read_response, read_data);
    end
  endtask

  task automatic test_rmw();
    rw_address = 32'h0000_1000;
    write_data = 32'h0000_AB00;
    write_strobe = 4'b0010;
    write_request = 1'b1;
    tick();
    write_request = 1'b0;
    n_vec++;
    if (ch_read !== 2'b10 || ch_write !== 2'b00) begin
      n_err++;
      $display("FAIL rmw_rd rd=%b wr=%b req=10/00",
               ch_read, ch_write);
    end
    ch_ready = 2'b10;
    ch_read_data[63:32] = 32'h1122_3344;
    tick();
    ch_ready = 2'b00;
    n_vec++;
    if (ch_read !== 2'b00 || ch_write !== 2'b10 ||
        ch_write_data !== 32'h1122_AB44 ||
        write_response !== 1'b0) begin
      n_err++;
      $display("FAIL rmw_wr rd=%b wr=%b wd=%h rsp=%b req=00/10/1122ab44/0",
               ch_read, ch_write, ch_write_data, write_response);
    end
    ch_ready = 2'b10;
    tick();
    ch_ready = 2'b00;
    n_vec++;
    if (write_response !== 1'b1 || ch_write !== 2'b00) begin
      n_err++;
      $display("FAIL rmw_resp rsp=%b wr=%b req=1/00",
               write_response, ch_write);
    end
    tick();
    n_vec++;
    if (write_response !== 1'b0) begin
      n_err++;
      $display("FAIL rmw_single rsp=%b req=0", write_response);
    end
  endtask

  task automatic test_full_write();
    rw_address = 32'h0000_0200;
    write_data = 32'hCAFE_F00D;
    write_strobe = 4'hF;
    write_request = 1'b1;
    tick();
    write_request = 1'b0;
    n_vec++;
    if (ch_write !== 2'b01 || ch_read !== 2'b00 ||
        ch_write_data !== 32'hCAFE_F00D) begin
      n_err++;
      $display("FAIL wr_issue wr=%b rd=%b wd=%h req=01/00/cafef00d",
               ch_write, ch_read, ch_write_data);
    end
    ch_ready = 2'b01;
    tick();
    ch_ready = 2'b00;
    n_vec++;
    if (write_response !== 1'b1 || ch_write !== 2'b00) begin
      n_err++;
      $display("FAIL wr_resp rsp=%b wr=%b req=1/00",
               write_response, ch_write);
    end
    tick();
  endtask

  task automatic test_decode_miss();
    n_vec++;
    if (err_o !== 1'b0) begin
      n_err++;
      $display("FAIL miss_pre err=%b req=0", err_o);
    end
    rw_address = 32'h0000_0A8E;
    read_request = 1'b1;
    tick();
    read_request = 1'b0;
    n_vec++;
    if (ch_read !== 2'b00 || ch_write !== 2'b00 ||
        read_response !== 1'b0) begin
      n_err++;
      $display("FAIL miss_noch rd=%b wr=%b rsp=%b req=00/00/0",
               ch_read, ch_write, read_response);
    end
    tick();
    n_vec++;
    if (read_response !== 1'b1 || read_data !== 32'hDEAD_BEEF ||
        err_o !== 1'b1 || ch_read !== 2'b00) begin
      n_err++;
      $display("FAIL miss_resp rsp=%b data=%h err=%b rd=%b req=1/deadbeef/1/00",
               read_response, read_data, err_o, ch_read);
    end
    tick();
    n_vec++;
    if (read_response !== 1'b0 || err_o !== 1'b1) begin
      n_err++;
      $display("FAIL miss_sticky rsp=%b err=%b req=0/1",
               read_response, err_o);
    end
  endtask

  task automatic test_timeout();
    int held;
    rw_address = 32'h0000_0300;
    read_request = 1'b1;
    tick();
    read_request = 1'b0;
    held = 0;
    for (int k = 0; k < 12; k++) begin
      if (ch_read == 2'b01) held++;
      tick();
      if (read_response) break;
    end
    n_vec++;
    if (held !== 8) begin
      n_err++;
      $display("FAIL tmo_len held=%0d req=8", held);
    end
    n_vec++;
    if (read_response !== 1'b1 || read_data !== 32'hDEAD_BEEF ||
        ch_read !== 2'b00) begin
      n_err++;
      $display("FAIL tmo_resp rsp=%b data=%h rd=%b req=1/deadbeef/00",
               read_response, read_data, ch_read);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    rw_address = 32'h0000_0400;
    write_data = 32'h55AA_55AA;
    write_strobe = 4'hF;
    write_request = 1'b1;
    read_request = 1'b1;
    tick();
    write_request = 1'b0;
    read_request = 1'b0;
    n_vec++;
    if (ch_write !== 2'b01 || ch_read !== 2'b00) begin
      n_err++;
      $display("FAIL b2b_wr wr=%b rd=%b req=01/00",
               ch_write, ch_read);
    end
    ch_ready = 2'b01;
    tick();
    ch_ready = 2'b00;
    n_vec++;
    if (write_response !== 1'b1 || read_response !== 1'b0 ||
        ch_read !== 2'b00) begin
      n_err++;
      $display("FAIL b2b_wrsp wrsp=%b rrsp=%b rd=%b req=1/0/00",
               write_response, read_response, ch_read);
    end
    tick();
    n_vec++;
    if (ch_read !== 2'b01 || write_response !== 1'b0 ||
        ch_address !== 32'h400) begin
      n_err++;
      $display("FAIL b2b_rd rd=%b wrsp=%b addr=%h req=01/0/400",
               ch_read, write_response, ch_address);
    end
    ch_ready = 2'b01;
    ch_read_data[31:0] = 32'h0BAD_F00D;
    tick();
    ch_ready = 2'b00;
    n_vec++;
    if (read_response !== 1'b1 || read_data !== 32'h0BAD_F00D) begin
      n_err++;
      $display("FAIL b2b_rrsp rsp=%b data=%h req=1/0badf00d",
               read_response, read_data);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    rw_address = 32'h0000_0500;
    read_request = 1'b1;
    tick();
    read_request = 1'b0;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    n_vec++;
    if (ch_read !== 2'b00 || read_response !== 1'b0 ||
        err_o !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid rd=%b rsp=%b err=%b req=00/0/0",
               ch_read, read_response, err_o);
    end
    ch_ready = 2'b01;
    tick();
    ch_ready = 2'b00;
    tick();
    n_vec++;
    if (read_response !== 1'b0) begin
      n_err++;
      $display("FAIL rst_noresp rsp=%b req=0", read_response);
    end
    rw_address = 32'h0000_0600;
    read_request = 1'b1;
    tick();
    read_request = 1'b0;
    n_vec++;
    if (ch_read !== 2'b01) begin
      n_err++;
      $display("FAIL rst_new_rd rd=%b req=01", ch_read);
    end
    ch_ready = 2'b01;
    ch_read_data[31:0] = 32'h7777_8888;
    tick();
    ch_ready = 2'b00;
    n_vec++;
    if (read_response !== 1'b1 || read_data !== 32'h7777_8888) begin
      n_err++;
      $display("FAIL rst_new_rsp rsp=%b data=%h req=1/77778888",
               read_response, read_data);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_rmw();
    test_full_write();
    test_decode_miss();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_mem_router.md
Name: cpu_mem_router

Overview:
- Parametrised CPU-bus router between the RISC-V core IO port and N_CH memory-side channels (L1I, L1D, MMIO, ...).
- Decodes each request against per-channel address windows and holds the channel handshake until it completes.
- Performs read-modify-write for partial-strobe stores with correct byte-lane merging.
- Returns an error word on decode miss or channel timeout, so the core never hangs.

Parameters:
- N_CH, 2, number of downstream channels (1..8)
- AW, 32, address width
- REGION_BASE, {32'h0000_0A90, 32'h0000_0000}, packed N_CH*AW, inclusive window base per channel (channel 0 in LSBs)
- REGION_LIMIT, {32'hFFFF_FFFF, 32'h0000_0A8C}, packed N_CH*AW, inclusive window limit per channel
- TIMEOUT_CYCLES, 1024, wait cycles before abort; 0 disables the timeout
- ERR_DATA, 32'hDEAD_BEEF, read data returned on error

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- rw_address  in  AW  CPU address
- read_request  in  1  CPU read pulse/level
- write_request  in  1  CPU write pulse/level
- write_data  in  32  CPU store data, lane-aligned
- write_strobe  in  4  byte enables
- read_data  out  32  registered read data
- read_response  out  1  one-cycle read completion
- write_response  out  1  one-cycle write completion
- ch_read  out  N_CH  per-channel read request (level)
- ch_write  out  N_CH  per-channel write request (level)
- ch_address  out  AW  shared latched address
- ch_write_data  out  32  shared full-word write data (merged)
- ch_read_data  in  N_CH*32  per-channel read data
- ch_ready  in  N_CH  per-channel completion pulse
- err_o  out  1  sticky error flag; cleared by reset only

Behaviour:
- Reset (rstn=0 at posedge): state IDLE; all outputs 0; pending cleared. Takes effect mid-transaction: channel requests drop the next cycle and no response is issued.
- Decode: the lowest-index channel with base<=addr<=limit wins. No hit gives an error.
- FSM states: IDLE, RD_WAIT, RMW_RD, RMW_WR, WR_WAIT, RESP_ERR.
- IDLE: latch address, data, strobe and channel at the request edge (cycle T). ch_* asserts at T+1.
  - read goes to RD_WAIT
  - write with strobe 4'hF goes to WR_WAIT
  - write with other nonzero strobe goes to RMW_RD
  - write with strobe 0: write_response at T+1, no channel access
  - decode miss goes to RESP_ERR
- RD_WAIT: hold ch_read until ch_ready[sel]. Capture ch_read_data slice. read_response=1 and read_data valid on the cycle after ch_ready. Return to IDLE.
- RMW_RD: read the old word. On ready, merge: byte i = strobe[i] ? write_data[8i+:8] : old[8i+:8]. Then go to RMW_WR. ch_write is asserted the next cycle.
- WR_WAIT / RMW_WR: hold ch_write until ready. write_response is pulsed the cycle after. Then IDLE.
- RESP_ERR: one cycle, then IDLE.
  - read: read_data=ERR_DATA, read_response=1
  - write: write_response=1
  - err_o set
- Timeout: the counter resets on state entry. At TIMEOUT_CYCLES without ready, drop the request and go to RESP_ERR.
- Simultaneous read_request and write_request in IDLE: write is serviced first. The read is held in a pending flag and starts the cycle after write_response.
- Requests arriving outside IDLE are ignored; the core holds until it sees a response.
- ch_ready on a non-selected channel is ignored.
- read_data holds its last value between responses.

Optional Feature:
- Macro ROUTER_PERF_EN.
- Defined:
  - adds outputs perf_req_cnt (N_CH*32) and perf_stall_cnt (N_CH*32)
  - per-channel 32-bit saturating counts of accepted requests and wait-state cycles
  - cleared by reset
- Undefined: ports and counters are absent; behaviour otherwise identical.

Decomposition:
- Package router_pkg: FSM state enum, N_CH_MAX=8, ERR_DATA default, byte-merge function.
- One sub-module, router_decode: combinational window compare plus priority encode, producing sel index and hit.

Test Plan:
- Read 0x0000_0100, ch_ready[0] 3 cycles after ch_read[0] rises, data 0x1234_5678 -> read_response 1 cycle later, read_data=0x1234_5678, ch_read[1] never set.
- Write 0x0000_1000, strobe 4'b0010, data 0x0000_AB00, old word 0x1122_3344 -> ch_read[1] then ch_write[1] with ch_write_data=0x1122_AB44, one write_response.
- Router with a gap in the windows, read an address in the gap -> read_data=0xDEAD_BEEF, read_response 1 cycle, no ch_* activity, err_o=1.
- TIMEOUT_CYCLES=8, ch_ready never asserted -> ch_read drops after 8 wait cycles, ERR_DATA returned.
- Read and write asserted together -> write_response first, then ch_read asserted next cycle and read_response.
- rstn low during RD_WAIT -> ch_read=0 next cycle, no read_response; a new read after reset completes normally.
